// File: rtl/dram_cmd_scheduler_pkg.sv
// Shared types and address field positions for the DRAM command scheduler.
// The request struct is what the scheduler keeps in its queue per memory request.
package dram_cmd_scheduler_pkg;

  localparam int ADDRESS_WIDTH = 33;
  localparam int ROW_W         = 15;
  localparam int COL_W         = 11;
  localparam int BANK_W        = 4;

  localparam int ROW_MSB    = 32;
  localparam int ROW_LSB    = 18;
  localparam int COL_HI_MSB = 17;
  localparam int COL_HI_LSB = 10;
  localparam int BANK_MSB   = 9;
  localparam int BANK_LSB   = 8;
  localparam int BG_MSB     = 7;
  localparam int BG_LSB     = 6;
  localparam int COL_LO_MSB = 5;
  localparam int COL_LO_LSB = 3;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2
  } parsed_op_t;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4
  } dram_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACT      = 3'd1,
    S_WAIT_RCD = 3'd2,
    S_COLUMN   = 3'd3,
    S_WAIT_PRE = 3'd4,
    S_PRE      = 3'd5,
    S_WAIT_RP  = 3'd6
  } sched_states_t;

  typedef struct packed {
    parsed_op_t         op;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [BANK_W-1:0]  bank;
  } dram_req_t;

endpackage

// File: rtl/dram_cmd_scheduler_fifo.sv
// Synchronous FIFO with registered full/empty/count flags and no read bypass:
// a pushed entry becomes visible at the head one cycle after the push.
module sync_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      // Flags are derived from the pre-update count so they stay registered.
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + cnt_t'(1);
          full  <= (count == cnt_t'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - cnt_t'(1);
          full  <= 1'b0;
          empty <= (count == cnt_t'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Closed-page, strictly in-order DDR4 command scheduler: one request at a time,
// ACT -> RD/WR -> PRE, with commands only on DRAM ticks (every other clk).
module dram_cmd_scheduler
  import dram_cmd_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int T_RCD       = 24,
  parameter int T_RAS       = 52,
  parameter int T_RP        = 24,
  parameter int T_RTP       = 12,
  parameter int T_CWL       = 20,
  parameter int T_BURST     = 4,
  parameter int T_WR        = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  parsed_op_t                     in_op,
  input  logic [ADDRESS_WIDTH-1:0]       in_address,
  output logic                           queue_full,
  output logic                           queue_empty,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy,
  output logic                           overflow_err,
  output logic                           cmd_valid,
  output dram_cmd_t                      cmd,
  output logic [BANK_W-1:0]              cmd_bank,
  output logic [ROW_W-1:0]               cmd_row,
  output logic [COL_W-1:0]               cmd_col,
  output logic                           req_done
);

  localparam int T_WR_DONE = T_CWL + T_BURST + T_WR;
  localparam int MAX_A     = (T_RCD > T_RAS) ? T_RCD : T_RAS;
  localparam int MAX_B     = (T_RP > T_RTP) ? T_RP : T_RTP;
  localparam int MAX_C     = (T_WR_DONE > MAX_B) ? T_WR_DONE : MAX_B;
  localparam int MAX_T     = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW        = $clog2(MAX_T) + 1;

  typedef logic [CW-1:0] cnt_t;

  sched_states_t state, state_next;
  dram_cmd_t     issue;
  dram_req_t     in_req;
  dram_req_t     head;
  logic          dram_phase;
  logic          addr_unused;
  cnt_t          rcd_cnt, ras_cnt, col_cnt, rp_cnt;

  assign in_req.op   = in_op;
  assign in_req.row  = in_address[ROW_MSB:ROW_LSB];
  assign in_req.col  = {in_address[COL_HI_MSB:COL_HI_LSB], in_address[COL_LO_MSB:COL_LO_LSB]};
  assign in_req.bank = {in_address[BG_MSB:BG_LSB], in_address[BANK_MSB:BANK_LSB]};
  assign addr_unused = ^in_address[2:0];

  sync_req_fifo #(
    .WIDTH ($bits(dram_req_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (issue == CMD_PRE),
    .din   (in_req),
    .dout  (head),
    .full  (queue_full),
    .empty (queue_empty),
    .count (occupancy)
  );

  function automatic cnt_t tick_dec(input cnt_t v, input logic tick);
    return (tick && v != '0) ? v - cnt_t'(1) : v;
  endfunction

  // A constraint is met on the tick where its counter is about to reach zero.
  always_comb begin
    state_next = state;
    issue      = CMD_NONE;
    case (state)
      S_IDLE: begin
        if (dram_phase && !queue_empty) begin
          issue      = CMD_ACT;
          state_next = S_ACT;
        end
      end
      S_ACT:      state_next = S_WAIT_RCD;
      S_WAIT_RCD: begin
        if (dram_phase && rcd_cnt <= cnt_t'(1)) begin
          issue      = (head.op == OP_WRITE) ? CMD_WR : CMD_RD;
          state_next = S_COLUMN;
        end
      end
      S_COLUMN:   state_next = S_WAIT_PRE;
      S_WAIT_PRE: begin
        if (dram_phase && ras_cnt <= cnt_t'(1) && col_cnt <= cnt_t'(1)) begin
          issue      = CMD_PRE;
          state_next = S_PRE;
        end
      end
      S_PRE:      state_next = S_WAIT_RP;
      S_WAIT_RP: begin
        if (dram_phase && rp_cnt <= cnt_t'(1)) begin
          if (!queue_empty) begin
            issue      = CMD_ACT;
            state_next = S_ACT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      dram_phase   <= 1'b0;
      rcd_cnt      <= '0;
      ras_cnt      <= '0;
      col_cnt      <= '0;
      rp_cnt       <= '0;
      cmd_valid    <= 1'b0;
      cmd          <= CMD_NONE;
      cmd_bank     <= '0;
      cmd_row      <= '0;
      cmd_col      <= '0;
      req_done     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state      <= state_next;
      dram_phase <= ~dram_phase;
      rcd_cnt    <= (issue == CMD_ACT) ? cnt_t'(T_RCD) : tick_dec(rcd_cnt, dram_phase);
      ras_cnt    <= (issue == CMD_ACT) ? cnt_t'(T_RAS) : tick_dec(ras_cnt, dram_phase);
      col_cnt    <= (issue == CMD_RD)  ? cnt_t'(T_RTP) :
                    (issue == CMD_WR)  ? cnt_t'(T_WR_DONE) : tick_dec(col_cnt, dram_phase);
      rp_cnt     <= (issue == CMD_PRE) ? cnt_t'(T_RP) : tick_dec(rp_cnt, dram_phase);
      cmd_valid  <= (issue != CMD_NONE);
      cmd        <= issue;
      req_done   <= (issue == CMD_PRE);
      case (issue)
        CMD_ACT: begin
          cmd_bank <= head.bank;
          cmd_row  <= head.row;
        end
        CMD_RD, CMD_WR: begin
          cmd_bank <= head.bank;
          cmd_col  <= head.col;
        end
        CMD_PRE: cmd_bank <= head.bank;
        default: ;
      endcase
      if (in_valid && queue_full) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Scoreboard bench for dram_cmd_scheduler: directed requests queue their expected
// ACT/column/PRE commands; a negedge monitor checks each issued command and its timing.
module tb_dram_cmd_scheduler;
  import dram_cmd_scheduler_pkg::*;

  typedef struct {
    dram_cmd_t   cmd;
    logic [3:0]  bank;
    logic [14:0] row;
    logic [10:0] col;
    int          delta;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  parsed_op_t  in_op;
  logic [32:0] in_address;
  logic        queue_full;
  logic        queue_empty;
  logic [4:0]  occupancy;
  logic        overflow_err;
  logic        cmd_valid;
  dram_cmd_t   cmd;
  logic [3:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [10:0] cmd_col;
  logic        req_done;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   cmds_seen = 0;
  int   last_act = 0;
  int   last_pre = 0;
  bit   have_pre = 0;

  dram_cmd_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_op        (in_op),
    .in_address   (in_address),
    .queue_full   (queue_full),
    .queue_empty  (queue_empty),
    .occupancy    (occupancy),
    .overflow_err (overflow_err),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_bank     (cmd_bank),
    .cmd_row      (cmd_row),
    .cmd_col      (cmd_col),
    .req_done     (req_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [32:0] mk_addr(input logic [14:0] row, input logic [7:0] col_hi,
                                          input logic [1:0] ba, input logic [1:0] bg,
                                          input logic [2:0] col_lo);
    return {row, col_hi, ba, bg, col_lo, 3'b110};
  endfunction

  function automatic void expect_req(input parsed_op_t op, input logic [14:0] row,
                                     input logic [10:0] col, input logic [3:0] bank);
    exp_q.push_back('{CMD_ACT, bank, row, col, 0});
    exp_q.push_back('{(op == OP_WRITE) ? CMD_WR : CMD_RD, bank, row, col, 48});
    exp_q.push_back('{CMD_PRE, bank, row, col, (op == OP_WRITE) ? 136 : 104});
  endfunction

  // Called at posedge+1; holds in_valid for exactly one clock edge.
  task automatic applyStimulus(input parsed_op_t op, input logic [32:0] addr);
    in_valid   = 1'b1;
    in_op      = op;
    in_address = addr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitSeen(input int n, input int budget);
    int left = budget;
    while (cmds_seen < n && left > 0) begin
      @(posedge clk);
      #1;
      left--;
    end
    checkOutput("wait_cmds", cmds_seen >= n, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (req_done && !cmd_valid) checkOutput("req_done_alone", req_done, 0);
      if (cmd_valid) begin
        cmds_seen++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_cmd", cmd_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("cmd", cmd, mon_e.cmd);
          checkOutput("cmd_bank", cmd_bank, mon_e.bank);
          checkOutput("req_done", req_done, mon_e.cmd == CMD_PRE);
          case (mon_e.cmd)
            CMD_ACT: begin
              checkOutput("act_row", cmd_row, mon_e.row);
              if (have_pre) checkOutput("act_after_pre_ge48", (cyc - last_pre) >= 48, 1);
              last_act = cyc;
            end
            CMD_RD, CMD_WR: begin
              checkOutput("col", cmd_col, mon_e.col);
              checkOutput("col_delay", cyc - last_act, mon_e.delta);
            end
            default: begin
              checkOutput("pre_delay", cyc - last_act, mon_e.delta);
              last_pre = cyc;
              have_pre = 1;
            end
          endcase
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int act_ref;
    int guard;
    logic [4:0] iv;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = OP_READ;
    in_address = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_valid", cmd_valid, 0);
    checkOutput("rst_cmd", cmd, CMD_NONE);
    checkOutput("rst_fields", {cmd_bank, cmd_row, cmd_col}, 0);
    checkOutput("rst_req_done", req_done, 0);
    checkOutput("rst_full", queue_full, 0);
    checkOutput("rst_empty", queue_empty, 1);
    checkOutput("rst_occ", occupancy, 0);
    checkOutput("rst_ovf", overflow_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] read / write / ifetch sequence");
    expect_req(OP_READ,   15'h0001, 11'h000, 4'h0);
    expect_req(OP_WRITE,  15'h0001, 11'h000, 4'h0);
    expect_req(OP_IFETCH, 15'h7FFF, 11'h7F8, 4'hF);
    applyStimulus(OP_READ,   33'h0_0004_0000);
    applyStimulus(OP_WRITE,  33'h0_0004_0000);
    applyStimulus(OP_IFETCH, 33'h1_FFFF_FFC0);
    waitSeen(9, 2000);
    checkOutput("drain_empty", queue_empty, 1);
    checkOutput("drain_occ", occupancy, 0);
    repeat (60) @(posedge clk);
    #1;

    $display("[TB] seventeen back-to-back pushes");
    base = cmds_seen;
    for (int i = 0; i < 17; i++) begin
      iv = 5'(i);
      if (i < 16)
        expect_req(parsed_op_t'(i % 3), 15'(16'h0100 + i), {8'(i * 3), iv[2:0]}, iv[3:0]);
      applyStimulus(parsed_op_t'(i % 3), mk_addr(15'(16'h0100 + i), 8'(i * 3), iv[1:0], iv[3:2], iv[2:0]));
      if (i == 15) begin
        checkOutput("ovf_before_17th", overflow_err, 0);
        checkOutput("full_at_16", queue_full, 1);
      end
    end
    checkOutput("occ_16", occupancy, 16);
    checkOutput("full_after_17", queue_full, 1);
    checkOutput("ovf_set", overflow_err, 1);

    $display("[TB] push during PRE pop of full queue");
    waitSeen(base + 1, 60);
    act_ref = last_act;
    guard = 0;
    while (cyc < act_ref + 103 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid   = 1'b1;
    in_op      = OP_READ;
    in_address = 33'h0_1234_5678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("occ_after_pop_push", occupancy, 15);
    checkOutput("full_after_pop", queue_full, 0);
    checkOutput("ovf_sticky", overflow_err, 1);
    @(negedge clk);
    checkOutput("pre_on_push_cycle", cmd, CMD_PRE);
    @(posedge clk);
    #1;

    $display("[TB] reset during WAIT_RCD");
    waitSeen(base + 4, 200);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    have_pre = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("abort_cmd_valid", cmd_valid, 0);
    checkOutput("abort_cmd", cmd, CMD_NONE);
    checkOutput("abort_occ", occupancy, 0);
    checkOutput("abort_empty", queue_empty, 1);
    checkOutput("abort_full", queue_full, 0);
    checkOutput("abort_ovf", overflow_err, 0);
    base = cmds_seen;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("no_cmd_after_abort", cmds_seen, base);

    $display("[TB] write after abort");
    expect_req(OP_WRITE, 15'h1234, 11'h2D5, 4'h9);
    applyStimulus(OP_WRITE, mk_addr(15'h1234, 8'h5A, 2'd1, 2'd2, 3'd5));
    waitSeen(base + 3, 400);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
